afifo_wr_arbiter: RTL and testbench
===================================

Name: afifo_wr_arbiter

Overview:
- Shares the single write port of the asynchronous FIFO among NREQ requesters, such as JTAG DR capture sources, in the FIFO write-clock domain.
- Arbitration is round-robin and packet-locked: a granted requester keeps the port until it sends a beat with last, or until MAX_BURST beats.
- Drives winc/wdata and honours full, so the FIFO is never written while full.

Parameters:
- DATA_WIDTH, 8: width of each data beat and of the FIFO write data.
- NREQ, 4: number of requesters, 2..16.
- MAX_BURST, 16: maximum beats per grant before forced release, 1..256.

Ports:
- clk  input  1: write-side clock, the same clock as the FIFO wclk.
- nrst  input  1: asynchronous, active-low reset.
- req_valid  input  NREQ: per-requester beat valid.
- req_data  input  NREQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NREQ: marks the final beat of a packet.
- req_ready  output  NREQ: per-requester accept; a beat transfers when valid && ready.
- fifo_full  input  1: FIFO full flag.
- fifo_winc  output  1: FIFO write enable.
- fifo_wdata  output  DATA_WIDTH: FIFO write data.
- grant_id  output  $clog2(NREQ): currently or most recently granted requester.
- busy  output  1: high while a grant is held (state LOCKED).

Behaviour:
- Reset (nrst low, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - Outputs: req_ready=0, fifo_winc=0, fifo_wdata=0, busy=0.
- States: IDLE, LOCKED.
- IDLE:
  - req_ready is all zeros; fifo_winc=0.
  - If any req_valid is set, pick the first valid index searching upward from rr_ptr, wrapping modulo NREQ.
  - Register the pick into grant_id and go to LOCKED next edge, with beat_cnt=0.
  - No valid: stay in IDLE.
  - Arbitration latency is exactly 1 cycle, from valid first seen in IDLE to ready possible.
- LOCKED, with g=grant_id:
  - Ready: req_ready[g] = !fifo_full, combinational. All other req_ready bits are 0.
  - Transfer condition: xfer = req_valid[g] && !fifo_full.
  - FIFO outputs: fifo_winc = xfer; fifo_wdata = req_data[g] when xfer, else 0.
  - On xfer: beat_cnt increments.
  - Release when xfer and (req_last[g] || beat_cnt == MAX_BURST-1):
    - next state IDLE, rr_ptr = (g+1) mod NREQ, beat_cnt=0.
  - Granted requester drops valid mid-packet: lock is held indefinitely and no other requester is served. This preserves packet integrity.
  - fifo_full high: no write, no ready, state and beat_cnt unchanged. Resume on the first cycle full is low.
- Back-to-back packets: a release is always followed by at least one IDLE cycle, so the sustained rate is ≤ MAX_BURST beats per MAX_BURST+1 cycles.
- Fairness:
  - rr_ptr only advances on release.
  - A requester continuously asserting valid is granted within NREQ-1 grants of others.
- Simultaneous events:
  - full rising in the same cycle as last: no transfer, no release.
  - req_last on a non-granted requester is ignored.
- fifo_winc is combinational from fifo_full and req_valid. Integrators must register nothing between this block and the FIFO write port.
- Reset mid-packet: immediately IDLE, no further winc. A partial packet may already be in the FIFO; that is the consumer's responsibility.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr and grant_id wrap modulo NREQ; non-power-of-2 NREQ must never select an index ≥ NREQ.

Test Plan:
- Single packet: reset, then req_valid[2]=1 with data 0xA1, 0xA2, 0xA3 and last on 0xA3 → grant_id=2 one cycle after valid. winc pulses 3 consecutive cycles with wdata 0xA1, 0xA2, 0xA3, then busy=0 and rr_ptr=3.
- Round-robin: all 4 requesters valid with single-beat packets (last=1) → grant order 0,1,2,3,0 with one IDLE bubble between grants; no requester is granted twice before the others.
- Full backpressure: mid-packet, hold fifo_full=1 for 5 cycles → req_ready and winc stay 0 for those 5 cycles. The pending beat is written on the first cycle with full=0, with no duplicate and no loss.
- Burst cap: MAX_BURST=4, requester 1 streams 10 beats with no last, requester 0 also valid → requester 1 is released after 4 beats; the next grant goes to requester 2 (rr_ptr=2) if valid, else wraps to 0.
- Valid gap: granted requester deasserts valid for 3 cycles mid-packet while others are valid → no grant change, no winc. The packet completes after valid returns.
- Async reset: assert nrst low mid-packet between clock edges → req_ready, winc and busy are 0 immediately. After release, a fresh arbitration starts from rr_ptr=0.

Source files
------------

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the async FIFO write port among NREQ requesters.
// A grant is held until a beat with last transfers or MAX_BURST beats have been written.
//
// state  | meaning
// IDLE   | no grant held; pick the next valid requester from rr_ptr upward
// LOCKED | grant_id owns the write port until last or the burst cap

module afifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NREQ       = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_winc,
    output logic [DATA_WIDTH-1:0]      fifo_wdata,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  beat_cnt;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   next_ptr;
    logic              locked;
    logic              g_valid;
    logic              g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic              xfer;
    logic              rel;

    // Scan downward so the lowest offset from rr_ptr wins; the wrap keeps indices below NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (req_valid[j]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'(j);
            end
        end
    end

    assign next_ptr = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    assign locked  = (state == LOCKED);
    assign g_valid = req_valid[grant_id];
    assign g_last  = req_last[grant_id];
    assign g_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign xfer    = locked && g_valid && !fifo_full;
    assign rel     = xfer && (g_last || (beat_cnt == CNT_W'(MAX_BURST - 1)));

    // Write strobe stays combinational so the FIFO sees full in the same cycle.
    always_comb begin
        req_ready = '0;
        if (locked && !fifo_full) req_ready[grant_id] = 1'b1;
    end

    assign fifo_winc  = xfer;
    assign fifo_wdata = xfer ? g_data : '0;
    assign busy       = locked;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (rel) begin
                        state    <= IDLE;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter (NREQ=4, MAX_BURST=4): packet flow, round-robin,
// backpressure, burst cap, valid gaps and async reset, with hand-computed expectations.

module tb_afifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;

    logic              clk;
    logic              nrst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_winc;
    logic [DW-1:0]     fifo_wdata;
    logic [1:0]        grant_id;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    afifo_wr_arbiter #(.DATA_WIDTH(DW), .NREQ(NR), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [NR-1:0] rdy, input logic winc,
                           input logic [DW-1:0] wd, input logic bsy);
        chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".winc"},  32'(fifo_winc), 32'(winc));
        chk({tag, ".wdata"}, 32'(fifo_wdata), 32'(wd));
        chk({tag, ".busy"},  32'(busy), 32'(bsy));
    endtask

    task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
        req_valid[i]          = v;
        req_data[i*DW +: DW]  = d;
        req_last[i]           = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 4'b0000, 1'b0, 8'h00, 1'b0);
        chk("reset.grant", 32'(grant_id), 32'd0);
        step();
        nrst = 1'b1;
        #1;

        // Single packet on requester 2
        set_req(2, 1'b1, 8'hA1, 1'b0);
        #1; chk_out("pkt.idle", 4'b0000, 1'b0, 8'h00, 1'b0);
        step(); #1;
        chk("pkt.grant", 32'(grant_id), 32'd2);
        chk_out("pkt.b0", 4'b0100, 1'b1, 8'hA1, 1'b1);
        step(); set_req(2, 1'b1, 8'hA2, 1'b0); #1;
        chk_out("pkt.b1", 4'b0100, 1'b1, 8'hA2, 1'b1);
        step(); set_req(2, 1'b1, 8'hA3, 1'b1); #1;
        chk_out("pkt.b2", 4'b0100, 1'b1, 8'hA3, 1'b1);
        step(); set_req(2, 1'b0, 8'h00, 1'b0); #1;
        chk_out("pkt.done", 4'b0000, 1'b0, 8'h00, 1'b0);

        // Round-robin from rr_ptr=3 with single-beat packets
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
        #1; chk("rr.idle.busy", 32'(busy), 32'd0);
        for (int k = 0; k < 5; k++) begin
            int e;
            e = (3 + k) % NR;
            step(); #1;
            chk("rr.grant", 32'(grant_id), 32'(e));
            chk_out("rr.beat", 4'(1 << e), 1'b1, 8'(8'h10 + e), 1'b1);
            step(); #1;
            chk_out("rr.bubble", 4'b0000, 1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'h00, 1'b0);

        // Full backpressure, including full coinciding with last
        set_req(1, 1'b1, 8'hB1, 1'b0);
        #1; chk_out("full.idle", 4'b0000, 1'b0, 8'h00, 1'b0);
        step(); #1;
        chk("full.grant", 32'(grant_id), 32'd1);
        chk_out("full.b0", 4'b0010, 1'b1, 8'hB1, 1'b1);
        step(); set_req(1, 1'b1, 8'hB2, 1'b0); fifo_full = 1'b1; #1;
        chk_out("full.hold", 4'b0000, 1'b0, 8'h00, 1'b1);
        repeat (4) begin
            step(); #1;
            chk_out("full.hold", 4'b0000, 1'b0, 8'h00, 1'b1);
        end
        step(); fifo_full = 1'b0; #1;
        chk_out("full.resume", 4'b0010, 1'b1, 8'hB2, 1'b1);
        step(); set_req(1, 1'b1, 8'hB3, 1'b1); fifo_full = 1'b1; #1;
        chk_out("full.last_blocked", 4'b0000, 1'b0, 8'h00, 1'b1);
        step(); fifo_full = 1'b0; #1;
        chk_out("full.last", 4'b0010, 1'b1, 8'hB3, 1'b1);
        step(); set_req(1, 1'b0, 8'h00, 1'b0); #1;
        chk_out("full.done", 4'b0000, 1'b0, 8'h00, 1'b0);

        // Burst cap: requester 1 streams without last, released after MB beats
        set_req(1, 1'b1, 8'hC0, 1'b0);
        #1; chk("cap.idle.busy", 32'(busy), 32'd0);
        step(); #1;
        chk("cap.grant", 32'(grant_id), 32'd1);
        chk_out("cap.b0", 4'b0010, 1'b1, 8'hC0, 1'b1);
        set_req(0, 1'b1, 8'h55, 1'b1);
        set_req(2, 1'b1, 8'h66, 1'b1);
        for (int b = 1; b < MB; b++) begin
            step(); set_req(1, 1'b1, 8'(8'hC0 + b), 1'b0); #1;
            chk_out("cap.beat", 4'b0010, 1'b1, 8'(8'hC0 + b), 1'b1);
        end
        step(); set_req(1, 1'b1, 8'hC4, 1'b0); #1;
        chk_out("cap.release", 4'b0000, 1'b0, 8'h00, 1'b0);
        step(); #1;
        chk("cap.next_grant", 32'(grant_id), 32'd2);
        chk_out("cap.req2", 4'b0100, 1'b1, 8'h66, 1'b1);
        step(); set_req(2, 1'b0, 8'h00, 1'b0); #1;
        chk_out("cap.bubble2", 4'b0000, 1'b0, 8'h00, 1'b0);
        step(); #1;
        chk("cap.wrap_grant", 32'(grant_id), 32'd0);
        chk_out("cap.req0", 4'b0001, 1'b1, 8'h55, 1'b1);
        step(); set_req(0, 1'b0, 8'h00, 1'b0); #1;
        chk_out("cap.bubble0", 4'b0000, 1'b0, 8'h00, 1'b0);
        step(); #1;
        chk("cap.regrant", 32'(grant_id), 32'd1);
        chk_out("cap.c4", 4'b0010, 1'b1, 8'hC4, 1'b1);

        // Valid gap: requester 1 drops valid for 3 cycles while requester 0 waits
        step(); set_req(1, 1'b0, 8'hC5, 1'b0); set_req(0, 1'b1, 8'h77, 1'b1); #1;
        chk_out("gap.hold", 4'b0010, 1'b0, 8'h00, 1'b1);
        repeat (2) begin
            step(); #1;
            chk("gap.grant", 32'(grant_id), 32'd1);
            chk_out("gap.hold", 4'b0010, 1'b0, 8'h00, 1'b1);
        end
        step(); set_req(1, 1'b1, 8'hC5, 1'b1); #1;
        chk_out("gap.resume", 4'b0010, 1'b1, 8'hC5, 1'b1);
        step(); set_req(1, 1'b0, 8'h00, 1'b0); #1;
        chk_out("gap.done", 4'b0000, 1'b0, 8'h00, 1'b0);
        step(); #1;
        chk("gap.next_grant", 32'(grant_id), 32'd0);
        chk_out("gap.req0", 4'b0001, 1'b1, 8'h77, 1'b1);
        step(); set_req(0, 1'b0, 8'h00, 1'b0); #1;
        chk_out("gap.idle", 4'b0000, 1'b0, 8'h00, 1'b0);

        // Async reset mid-packet on requester 3
        set_req(3, 1'b1, 8'hD0, 1'b0);
        step(); #1;
        chk("rst.grant3", 32'(grant_id), 32'd3);
        chk_out("rst.d0", 4'b1000, 1'b1, 8'hD0, 1'b1);
        step(); set_req(3, 1'b1, 8'hD1, 1'b0); #1;
        chk_out("rst.d1", 4'b1000, 1'b1, 8'hD1, 1'b1);
        #2; nrst = 1'b0; #1;
        chk_out("rst.async", 4'b0000, 1'b0, 8'h00, 1'b0);
        chk("rst.async.grant", 32'(grant_id), 32'd0);
        step(); #1;
        chk_out("rst.held", 4'b0000, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'hE0, 1'b1);
        nrst = 1'b1; #1;
        chk_out("rst.post_idle", 4'b0000, 1'b0, 8'h00, 1'b0);
        step(); #1;
        chk("rst.fresh_grant", 32'(grant_id), 32'd0);
        chk_out("rst.e0", 4'b0001, 1'b1, 8'hE0, 1'b1);
        step(); for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'h00, 1'b0); #1;
        chk_out("rst.end", 4'b0000, 1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
